// File: rtl/opcode_proc_arbiter_if.sv
// rtl/opcode_proc_arbiter_if.sv - requester-side request/response bus of the opcode processor arbiter
interface opcode_proc_arbiter_if #(
    parameter int NREQ = 4,
    parameter int OPW  = 4,
    parameter int DW   = 8
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*OPW-1:0] req_opcode;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     rsp_valid;
    logic [DW-1:0]       rsp_result;

    modport master (
        output req_valid, req_opcode, req_data,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_opcode, req_data,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/opcode_proc_arbiter.sv
// rtl/opcode_proc_arbiter.sv - shares one opcode processor among NREQ requesters (OPA_FIXED_PRIO_EN: fixed priority)
module opcode_proc_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int OPW  = 4,
    parameter int DW   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    opcode_proc_arbiter_if.slave bus,
    output logic [OPW-1:0]       proc_opcode,
    output logic [DW-1:0]        proc_data,
    input  logic [DW-1:0]        proc_result,
    output logic                 busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   win;
    logic [GW-1:0]   idx;
    logic            found;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] rsp_valid;
    logic [DW-1:0]   rsp_result;
    logic [OPW-1:0]  win_opcode;
    logic [DW-1:0]   win_data;

`ifndef OPA_FIXED_PRIO_EN
    logic [GW-1:0]   last;
`endif

    // Loops run from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
`ifdef OPA_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                found = 1'b1;
                win   = GW'(i);
            end
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            idx = GW'((int'(last) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`endif
        win_opcode = '0;
        win_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
                win_opcode = bus.req_opcode[i*OPW +: OPW];
                win_data   = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign bus.req_ready  = (state == IDLE && found) ? (NREQ'(1) << win) : '0;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            proc_opcode <= '0;
            proc_data   <= '0;
            busy        <= 1'b0;
`ifndef OPA_FIXED_PRIO_EN
            last        <= GW'(NREQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        proc_opcode <= win_opcode;
                        proc_data   <= win_data;
                        grant       <= win;
`ifndef OPA_FIXED_PRIO_EN
                        last        <= win;
`endif
                        cnt         <= CW'(LAT - 1);
                        busy        <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt==0 marks exactly LAT edges since the accept edge.
                    if (cnt == '0) begin
                        rsp_result <= proc_result;
                        rsp_valid  <= NREQ'(1) << grant;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_opcode_proc_arbiter.sv
// tb/tb_opcode_proc_arbiter.sv - directed and random checks of opcode_proc_arbiter at LAT=1 (ifa) and LAT=3 (ifb)
module tb_opcode_proc_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    opcode_proc_arbiter_if #(.NREQ(4), .OPW(4), .DW(8)) ifa ();
    opcode_proc_arbiter_if #(.NREQ(4), .OPW(4), .DW(8)) ifb ();

    logic [3:0] op_a, op_b;
    logic [7:0] data_a, data_b, res_a, res_b, s1_b, s2_b;
    logic       busy_a, busy_b;

    function automatic logic [7:0] f(input logic [3:0] op, input logic [7:0] d);
        return (d ^ {op, ~op}) + {4'h0, op};
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    // Processor models: combinational for LAT=1, two register stages for LAT=3.
    assign res_a = f(op_a, data_a);
    always @(posedge clk) begin
        s1_b <= f(op_b, data_b);
        s2_b <= s1_b;
    end
    assign res_b = s2_b;

    opcode_proc_arbiter #(.NREQ(4), .LAT(1), .OPW(4), .DW(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .proc_opcode(op_a),
        .proc_data(data_a), .proc_result(res_a), .busy(busy_a)
    );

    opcode_proc_arbiter #(.NREQ(4), .LAT(3), .OPW(4), .DW(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .proc_opcode(op_b),
        .proc_data(data_b), .proc_result(res_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seen, bad;
        logic       got;
        int         t, exp_g, last_acc, low, acc;
        logic [3:0] c_op [4];
        logic [7:0] c_d [4];
        logic [3:0] r_op [4];
        logic [7:0] r_d [4];
        logic [63:0] cov;
        logic [3:0] clr, accv;
        logic       pend;
        int         pg, guard;
        logic [7:0] pr;

        ifa.req_valid = '0; ifa.req_opcode = '0; ifa.req_data = '0;
        ifb.req_valid = '0; ifb.req_opcode = '0; ifb.req_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a", {ifa.req_ready, ifa.rsp_valid, ifa.rsp_result, op_a, data_a, busy_a}, 0);
        check("rst_b", {ifb.req_ready, ifb.rsp_valid, ifb.rsp_result, op_b, data_b, busy_b}, 0);
        rst_n = 1'b1;

        // Reset while WAIT on LAT=3
        @(negedge clk);
        ifb.req_valid[1] = 1'b1; ifb.req_opcode[7:4] = 4'h5; ifb.req_data[15:8] = 8'h12;
        #1 check("rstw_ready", ifb.req_ready, 4'b0010);
        @(negedge clk);
        ifb.req_valid = '0;
        check("rstw_accept", {busy_b, op_b, data_b}, {1'b1, 4'h5, 8'h12});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rstw_async", {busy_b, op_b, data_b, ifb.rsp_valid, ifb.rsp_result}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = '0;
        repeat (8) begin
            @(negedge clk);
            seen |= ifb.rsp_valid;
        end
        check("rstw_no_rsp", {seen, busy_b}, 0);
        ifb.req_valid[3] = 1'b1; ifb.req_opcode[15:12] = 4'hA; ifb.req_data[31:24] = 8'h3C;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (busy_b) ifb.req_valid = '0;
            if (ifb.rsp_valid != '0) begin
                got = 1'b1;
                check("rstw_rsp_valid", ifb.rsp_valid, 4'b1000);
                check("rstw_rsp_result", ifb.rsp_result, f(4'hA, 8'h3C));
            end
        end
        check("rstw_rsp_seen", got, 1);

        // Single request on LAT=1
        @(negedge clk);
        ifa.req_valid[2] = 1'b1; ifa.req_opcode[11:8] = 4'h3; ifa.req_data[23:16] = 8'h55;
        #1 check("single_ready", ifa.req_ready, 4'b0100);
        @(negedge clk);
        ifa.req_valid = '0;
        check("single_proc", {op_a, data_a, busy_a, ifa.rsp_valid}, {4'h3, 8'h55, 1'b1, 4'b0000});
        @(negedge clk);
        check("single_rsp_valid", ifa.rsp_valid, 4'b0100);
        check("single_rsp_result", ifa.rsp_result, f(4'h3, 8'h55));
        @(negedge clk);
        check("single_after", {ifa.rsp_valid, busy_a, ifa.rsp_result, op_a}, {4'b0000, 1'b0, f(4'h3, 8'h55), 4'h3});

        // Contention from a fresh pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_op[i] = 4'(i * 3 + 1);
            c_d[i]  = 8'(8'h10 * i + 7);
            ifa.req_opcode[i*4 +: 4] = c_op[i];
            ifa.req_data[i*8 +: 8]   = c_d[i];
        end
        ifa.req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            t = 0;
            while (ifa.req_ready == '0 && t < 20) begin @(negedge clk); t++; end
`ifdef OPA_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % 4;
`endif
            check("cont_grant", ifa.req_ready, oh(exp_g));
            @(negedge clk);
            t = 0;
            while (ifa.rsp_valid == '0 && t < 20) begin @(negedge clk); t++; end
            check("cont_rsp_valid", ifa.rsp_valid, oh(exp_g));
            check("cont_rsp_result", ifa.rsp_result, f(c_op[exp_g], c_d[exp_g]));
        end
        ifa.req_valid = '0;
        repeat (4) @(negedge clk);

        // Throughput on LAT=3
        ifb.req_opcode = 16'h7351; ifb.req_data = 32'h11223344;
        ifb.req_valid = 4'b0101;
        last_acc = 0; low = 0; acc = 0;
        for (int k = 0; k < 100 && acc < 4; k++) begin
            @(negedge clk);
            #1;
            if (!busy_b) low++;
            if ((ifb.req_ready & ifb.req_valid) != '0) begin
                if (acc > 0) begin
                    check("tput_gap", cyc - last_acc, 5);
                    check("tput_busy_low", low, 1);
                end
                last_acc = cyc; low = 0; acc++;
            end
        end
        check("tput_done", acc, 4);
        @(negedge clk);
        ifb.req_valid = '0;
        repeat (8) @(negedge clk);

        // Abandoned request while busy
        ifa.req_valid = 4'b0001; ifa.req_opcode[3:0] = 4'h9; ifa.req_data[7:0] = 8'h81;
        #1 check("abandon_ready0", ifa.req_ready, 4'b0001);
        bad = '0;
        @(negedge clk);
        ifa.req_valid = 4'b0010; ifa.req_opcode[7:4] = 4'h6; ifa.req_data[15:8] = 8'hC3;
        #1 bad[0] = ifa.req_ready[1];
        @(negedge clk);
        ifa.req_valid = '0;
        check("abandon_rsp_valid", ifa.rsp_valid, 4'b0001);
        check("abandon_rsp_result", ifa.rsp_result, f(4'h9, 8'h81));
        repeat (8) begin
            @(negedge clk);
            bad[1] = bad[1] | ifa.req_ready[1] | ifa.rsp_valid[1];
        end
        check("abandon_none", bad, 0);

        // Random closure with scoreboard and opcode x requester coverage
        cov = '0; clr = '0; pend = 1'b0; pg = 0; pr = '0; guard = 0;
        while ($countones(cov) < 64 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (ifa.rsp_valid != '0) begin
                check("rnd_pend", pend, 1);
                check("rnd_rsp_valid", ifa.rsp_valid, oh(pg));
                check("rnd_rsp_result", ifa.rsp_result, pr);
                pend = 1'b0;
            end
            ifa.req_valid = ifa.req_valid & ~clr;
            clr = '0;
            for (int i = 0; i < 4; i++) begin
                if (!ifa.req_valid[i] && $urandom_range(1, 0) == 1) begin
                    r_op[i] = 4'($urandom_range(15, 0));
                    r_d[i]  = 8'($urandom_range(255, 0));
                    ifa.req_opcode[i*4 +: 4] = r_op[i];
                    ifa.req_data[i*8 +: 8]   = r_d[i];
                    ifa.req_valid[i] = 1'b1;
                end
            end
            #1;
            accv = ifa.req_ready & ifa.req_valid;
            if (accv != '0) begin
                check("rnd_onehot", $onehot(accv), 1);
                for (int i = 0; i < 4; i++) if (accv[i]) pg = i;
                pr = f(r_op[pg], r_d[pg]);
                pend = 1'b1;
                cov[r_op[pg] * 4 + pg] = 1'b1;
                clr = accv;
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) ifa.req_valid = '0;
            if (ifa.rsp_valid != '0) begin
                check("rnd_drain_valid", ifa.rsp_valid, oh(pg));
                check("rnd_drain_result", ifa.rsp_result, pr);
                pend = 1'b0;
            end
        end
        check("rnd_drain", pend, 0);
        check("rnd_coverage", $countones(cov), 64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/opcode_proc_arbiter.md
Name: opcode_proc_arbiter

Overview:
- Shares one opcode_processor datapath (4-bit opcode, 8-bit data, 8-bit result) between NREQ independent requesters.
- Each requester presents an opcode/data pair with a valid/ready handshake.
- The arbiter selects one requester, drives the processor inputs, waits the processor latency, then returns the result to that requester with a one-cycle response pulse.
- Sits between the requesters and the opcode_processor instance; it is the only driver of the processor's opcode/data inputs.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 1, cycles from processor inputs changing to proc_result being valid (>=1)
- OPW, 4, opcode width
- DW, 8, data/result width

Ports:
- clk  in  1  clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, at most one bit set
- req_opcode  in  NREQ*OPW  requester i at [i*OPW +: OPW]
- req_data  in  NREQ*DW  requester i at [i*DW +: DW]
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the granted requester
- rsp_result  out  DW  result for the current rsp_valid
- proc_opcode  out  OPW  to processor opcode input, registered
- proc_data  out  DW  to processor data input, registered
- proc_result  in  DW  from processor result output
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset state: FSM=IDLE; req_ready=0, rsp_valid=0, rsp_result=0, proc_opcode=0, proc_data=0, busy=0; round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational and one-hot for the winner among the set req_valid bits; it is 0 if no request is valid.
  - A transfer occurs on the edge where req_valid[g] & req_ready[g].
  - On that edge: proc_opcode/proc_data <= requester g's fields; grant register <= g; last <= g; cnt <= LAT-1; next state WAIT.
- Round-robin: search order is last+1, last+2, ... wrapping modulo NREQ.
- WAIT:
  - req_ready=0.
  - cnt decrements each cycle.
  - On the edge where cnt==0: rsp_result <= proc_result; rsp_valid <= one-hot(grant); next state RESP.
  - proc_result is therefore sampled exactly LAT edges after the accept edge.
- RESP:
  - rsp_valid is high for exactly one cycle.
  - Next edge: rsp_valid <= 0; next state IDLE.
- Hold rules:
  - proc_opcode/proc_data hold their value until the next accept; they are never returned to 0 except by reset.
  - rsp_result holds its value until the next response.
- Throughput: one operation per LAT+2 cycles with continuous requests.
- Requester rules:
  - A requester must hold valid and payload stable until accepted.
  - Dropping valid before ready is permitted; no transfer occurs and no state change results.
- Simultaneous events: multiple valids are resolved by the arbitration order only. A requester re-asserting valid in the RESP cycle is considered in the following IDLE cycle.
- Reset mid-operation (WAIT or RESP): the transaction is dropped, no rsp_valid is issued, and all outputs return to reset values immediately (asynchronously).
- Widths: no arithmetic beyond the cnt counter, which is $clog2(LAT+1) bits wide. The index g is $clog2(NREQ) bits wide.

Optional Feature:
- Macro: OPA_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins and the last pointer is unused.
- Undefined (default): round-robin as described above.
- Handshake, latency and response timing are identical in both modes.

Test Plan:
- Reset: assert rst_n=0 in WAIT with LAT=3 -> outputs 0 asynchronously, no rsp_valid after release, busy=0; then a single request completes normally.
- Single request: requester 2, opcode 4'h3, data 8'h55, LAT=1 -> req_ready=4'b0100 in the first IDLE cycle; proc_opcode=3, proc_data=8'h55 after that edge; rsp_valid=4'b0100 for one cycle with rsp_result equal to proc_result one edge after accept.
- Contention: all four req_valid held high -> grant order 0,1,2,3,0,1. With OPA_FIXED_PRIO_EN -> 0,0,0,0.
- Throughput: LAT=3 with continuous requests -> accept edges spaced exactly 5 cycles apart; busy low for exactly one cycle between operations.
- Abandoned request: req_valid[1] pulsed for one cycle while busy -> no req_ready[1] and no rsp_valid[1] ever.
- Random closure: constrained-random opcode/data/valid on all requesters, with a scoreboard checking rsp_result against a processor model. Coverage of opcode 0..15 crossed with requester 0..3 must reach 100%, ending on the coverage goal rather than a fixed cycle count.
